// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller:
// hex glyph table (active-low, g..a), all-off pin value, FSM states, index width helper.
package seg_pkg;

  typedef logic [6:0] seg_pattern_t;

  typedef enum logic {
    ST_DEAD = 1'b0,
    ST_ON   = 1'b1
  } scan_state_t;

  // All segments and the dot dark, expressed in the active-low pin encoding.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam seg_pattern_t HEX_PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble + dot to 8-bit segment pins ([7] dot, [6:0] g..a).
// ACTIVE_LOW selects whether a lit segment drives the pin low or high.
module seg_hex_decode
  import seg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] i_nibble,
  input  logic       i_dot,
  output logic [7:0] o_seg
);

  logic [7:0] w_seg_al;

  assign w_seg_al = {~i_dot, HEX_PAT[i_nibble]};
  assign o_seg    = ACTIVE_LOW ? w_seg_al : ~w_seg_al;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed N-digit common-anode 7-segment scanner with double-buffered value and dead-time blanking.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking of the upper digits.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int PRESCALE       = 1024,
  parameter int DEAD           = 16,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic [DIGITS-1:0]     dots_i,
  input  logic                  load_i,
  input  logic                  blank_i,
  output logic                  pending_o,
  output logic                  frame_o,
  output logic [7:0]            seg_o,
  output logic [DIGITS-1:0]     dig_o
);

  localparam int CW = idx_width(PRESCALE);
  localparam int IW = idx_width(DIGITS);
  localparam logic [CW-1:0]     CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0]     DEAD_CNT = CW'(DEAD);
  localparam logic [IW-1:0]     IDX_TOP  = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] DIG_ONE  = DIGITS'(1);
  localparam logic [7:0]        OFF_PINS = (SEG_ACTIVE_LOW != 0) ? SEG_OFF : ~SEG_OFF;

  logic [CW-1:0]            r_cnt;
  logic [IW-1:0]            r_idx;
  scan_state_t              r_state;
  logic [DIGITS-1:0][3:0]   r_disp_val;
  logic [DIGITS-1:0]        r_disp_dots;
  logic [DIGITS-1:0][3:0]   r_pend_val;
  logic [DIGITS-1:0]        r_pend_dots;
  logic                     r_pending;
  logic [7:0]               r_seg;
  logic [DIGITS-1:0]        r_dig;

  logic [CW-1:0]            w_cnt_nxt;
  logic [IW-1:0]            w_idx_nxt;
  scan_state_t              w_state_nxt;
  logic                     w_slot_end;
  logic                     w_frame;
  logic [7:0]               w_seg_dec;
  logic [DIGITS-1:0]        w_lzb_dark;
  logic [7:0]               w_seg_nxt;
  logic [DIGITS-1:0]        w_dig_nxt;

  assign w_slot_end = (r_cnt == CNT_LAST);
  assign w_frame    = w_slot_end && (r_idx == '0);
  assign w_cnt_nxt  = w_slot_end ? '0 : r_cnt + 1'b1;
  assign w_idx_nxt  = (r_idx == '0) ? IDX_TOP : r_idx - 1'b1;

  seg_hex_decode #(
    .ACTIVE_LOW (SEG_ACTIVE_LOW != 0)
  ) u_decode (
    .i_nibble (r_disp_val[r_idx]),
    .i_dot    (r_disp_dots[r_idx]),
    .o_seg    (w_seg_dec)
  );

`ifdef SEG_SCAN_LZB_EN
  // A digit is dark only if it and every digit above it is a bare zero; digit 0 always shows.
  always_comb begin
    logic v_run_zero;
    v_run_zero = 1'b1;
    w_lzb_dark = '0;
    for (int j = DIGITS - 1; j > 0; j--) begin
      v_run_zero    = v_run_zero && (r_disp_val[j] == 4'h0) && !r_disp_dots[j];
      w_lzb_dark[j] = v_run_zero;
    end
  end
`else
  assign w_lzb_dark = '0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt   <= '0;
      r_idx   <= IDX_TOP;
      r_state <= ST_DEAD;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
      if (w_slot_end) begin
        r_idx <= w_idx_nxt;
      end
    end
  end

  // Next state tracks the next counter value; pin drive is decided from the current state.
  always_comb begin
    w_state_nxt = ST_DEAD;
    w_dig_nxt   = '0;
    w_seg_nxt   = OFF_PINS;
    if (w_cnt_nxt >= DEAD_CNT) begin
      w_state_nxt = ST_ON;
    end
    if ((r_state == ST_ON) && !blank_i && !w_lzb_dark[r_idx]) begin
      w_dig_nxt = DIG_ONE << r_idx;
      w_seg_nxt = w_seg_dec;
    end
  end

  // Load wins over the commit-clear, so a load on the boundary keeps pending set.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_disp_val  <= '0;
      r_disp_dots <= '0;
      r_pend_val  <= '0;
      r_pend_dots <= '0;
      r_pending   <= 1'b0;
    end else begin
      if (w_frame && r_pending) begin
        r_disp_val  <= r_pend_val;
        r_disp_dots <= r_pend_dots;
      end
      if (load_i) begin
        r_pend_val  <= value_i;
        r_pend_dots <= dots_i;
        r_pending   <= 1'b1;
      end else if (w_frame) begin
        r_pending   <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_seg <= OFF_PINS;
      r_dig <= '0;
    end else begin
      r_seg <= w_seg_nxt;
      r_dig <= w_dig_nxt;
    end
  end

  assign pending_o = r_pending;
  assign frame_o   = w_frame;
  assign seg_o     = r_seg;
  assign dig_o     = r_dig;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (DIGITS=4, PRESCALE=8, DEAD=2, active-low segments).
module tb_seg_scan_ctrl;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 8;
  localparam int DEAD     = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] value_i = '0;
  logic [3:0]  dots_i = '0;
  logic        load_i = 1'b0;
  logic        blank_i = 1'b0;
  logic        pending_o;
  logic        frame_o;
  logic [7:0]  seg_o;
  logic [3:0]  dig_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] hex_al [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg_scan_ctrl #(
    .DIGITS         (DIGITS),
    .PRESCALE       (PRESCALE),
    .DEAD           (DEAD),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .value_i   (value_i),
    .dots_i    (dots_i),
    .load_i    (load_i),
    .blank_i   (blank_i),
    .pending_o (pending_o),
    .frame_o   (frame_o),
    .seg_o     (seg_o),
    .dig_o     (dig_o)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advances at least one cycle; returns on the negedge of a frame_o cycle.
  task automatic wait_frame();
    int k;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (frame_o !== 1'b1 && k < 100);
    if (frame_o !== 1'b1) check("frame_timeout", frame_o, 1);
  endtask

  // Called on the negedge of a frame cycle; checks every pin cycle of the following frame
  // and returns on the negedge of the next frame cycle. Blank is high for n in [b, e).
  task automatic scan_frame(input logic [15:0] val, input logic [3:0] dts,
                            input logic pend_exp, input int b, input int e);
    logic [3:0] dark;
    logic       run;
    int         m;
    int         idx;
    logic       lit;
    logic [3:0] exp_dig;
    logic [7:0] exp_seg;
    dark = '0;
    run  = 1'b1;
`ifdef SEG_SCAN_LZB_EN
    for (int j = 3; j > 0; j--) begin
      run     = run && (val[4*j +: 4] == 4'h0) && !dts[j];
      dark[j] = run;
    end
`endif
    for (int n = 1; n <= 32; n++) begin
      @(negedge CLK);
      if (n == 1) begin
        load_i = 1'b0;
        check("pending_after_frame", pending_o, pend_exp);
      end
      check($sformatf("frame_o n=%0d", n), frame_o, (n == 32));
      if (n >= 2) begin
        m       = n - 2;
        idx     = 3 - m / 8;
        lit     = (m % 8 >= DEAD) && !dark[idx] && !(n > b && n <= e);
        exp_dig = lit ? (4'b0001 << idx) : 4'b0000;
        exp_seg = lit ? {~dts[idx], hex_al[val[4*idx +: 4]]} : 8'hFF;
        check($sformatf("dig val=%h n=%0d", val, n), dig_o, exp_dig);
        check($sformatf("seg val=%h n=%0d", val, n), seg_o, exp_seg);
      end
      if (n == b) blank_i = 1'b1;
      if (n == e) blank_i = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_dig", dig_o, 4'b0000);
    check("rst_seg", seg_o, 8'hFF);
    check("rst_pending", pending_o, 0);
    check("rst_frame", frame_o, 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("dead_after_rst", dig_o, 4'b0000);
    @(negedge CLK);
    check("first_on_dig", dig_o, 4'b1000);
    check("first_on_seg", seg_o, 8'hC0);

    // Reset in the middle of a lit slot with a load pending.
    repeat (10) @(negedge CLK);
    value_i = 16'h9999;
    load_i  = 1'b1;
    @(negedge CLK);
    load_i = 1'b0;
    check("pending_before_rst", pending_o, 1);
    #2 RST = 1'b1;
    #1;
    check("midrst_dig", dig_o, 4'b0000);
    check("midrst_seg", seg_o, 8'hFF);
    check("midrst_pending", pending_o, 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("restart_dead", dig_o, 4'b0000);
    @(negedge CLK);
    check("restart_on_dig", dig_o, 4'b1000);
    check("restart_on_seg", seg_o, 8'hC0);

    // Load, commit at the boundary, then a full frame of 12AF with dot on digit 1.
    @(negedge CLK);
    value_i = 16'h12AF;
    dots_i  = 4'b0010;
    load_i  = 1'b1;
    @(negedge CLK);
    load_i = 1'b0;
    check("pending_after_load", pending_o, 1);
    wait_frame();
    check("pending_at_frame", pending_o, 1);
    scan_frame(16'h12AF, 4'b0010, 1'b0, 0, 0);

    // Two loads before the boundary: last write wins.
    @(negedge CLK);
    value_i = 16'h1111;
    dots_i  = 4'b0000;
    load_i  = 1'b1;
    @(negedge CLK);
    value_i = 16'h2222;
    @(negedge CLK);
    load_i = 1'b0;
    wait_frame();
    scan_frame(16'h2222, 4'b0000, 1'b0, 0, 0);

    // Load coincident with the boundary: old pending commits, new one waits a frame.
    @(negedge CLK);
    value_i = 16'h3456;
    dots_i  = 4'b0001;
    load_i  = 1'b1;
    @(negedge CLK);
    load_i = 1'b0;
    wait_frame();
    value_i = 16'h789C;
    dots_i  = 4'b0100;
    load_i  = 1'b1;
    scan_frame(16'h3456, 4'b0001, 1'b1, 0, 0);
    scan_frame(16'h789C, 4'b0100, 1'b0, 0, 0);

    // Blank for 20 cycles; frame pulses and scan continue underneath.
    scan_frame(16'h789C, 4'b0100, 1'b0, 5, 25);
    scan_frame(16'h789C, 4'b0100, 1'b0, 0, 0);

    // Leading zeros, without and with a dot on the top digit.
    @(negedge CLK);
    value_i = 16'h0050;
    dots_i  = 4'b0000;
    load_i  = 1'b1;
    @(negedge CLK);
    load_i = 1'b0;
    wait_frame();
    scan_frame(16'h0050, 4'b0000, 1'b0, 0, 0);
    @(negedge CLK);
    dots_i = 4'b1000;
    load_i = 1'b1;
    @(negedge CLK);
    load_i = 1'b0;
    wait_frame();
    scan_frame(16'h0050, 4'b1000, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
